// File: rtl/md_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_pkg                                                                |
// | Shared definitions for the multi-cycle multiply/divide sequencer:     |
// | ALU op codes, FSM state encoding and small op-decode helpers.         |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package md_pkg;

   // Default operand width; HI/LO are this wide and one iteration per bit.
   localparam int MD_WIDTH = 32;

   // 5-bit ALU op codes shared with the ALU decoder.
   localparam logic [4:0] OP_DIV   = 5'b10001;
   localparam logic [4:0] OP_DIVU  = 5'b10010;
   localparam logic [4:0] OP_MULT  = 5'b10011;
   localparam logic [4:0] OP_MULTU = 5'b10100;

   // Sequencer states, explicitly 2 bits wide.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } md_state_e;

   // True for any op code this sequencer executes.
   function automatic logic is_md_op(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_MULT) || (op == OP_MULTU);
   endfunction

   // True for the signed variants (operands are two's complement).
   function automatic logic is_signed_op(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_MULT);
   endfunction

   // True for the divide variants.
   function automatic logic is_div_op(input logic [4:0] op);
      return (op == OP_DIV) || (op == OP_DIVU);
   endfunction

endpackage
`default_nettype wire

// File: rtl/md_iter_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | md_iter_step                                                          |
// | Combinational single iteration of the unsigned datapath:              |
// |  - multiply: shift-add, product pair shifts right one bit             |
// |  - divide:   restoring step, remainder/quotient pair shifts left      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module md_iter_step
   import md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic                 is_div,
   input  logic [2*WIDTH-1:0]   pair_in,
   input  logic [WIDTH-1:0]     operand,
   output logic [2*WIDTH-1:0]   pair_out
);

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   rem_shift;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_diff;

   // One iteration: multiplicand add into the upper half, or trial subtract of the divisor.
   always_comb begin
      // Multiply: upper half plus multiplicand when the current multiplier bit is set;
      // the carry becomes the new MSB after the right shift.
      mul_sum   = {1'b0, pair_in[2*WIDTH-1:WIDTH]} + (pair_in[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
      // Divide: remainder shifted left with the next dividend bit pulled in.
      rem_shift = pair_in[2*WIDTH-1:WIDTH-1];
      rem_ge    = (rem_shift >= {1'b0, operand});
      // When the subtraction succeeds the true difference is below the divisor, so it fits WIDTH bits.
      rem_diff  = rem_shift[WIDTH-1:0] - operand;

      if (is_div) begin
         if (rem_ge) begin
            pair_out = {rem_diff, pair_in[WIDTH-2:0], 1'b1};
         end else begin
            pair_out = {pair_in[2*WIDTH-2:0], 1'b0};
         end
      end else begin
         pair_out = {mul_sum, pair_in[WIDTH-1:1]};
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq                                                            |
// | Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers. |
// | Magnitudes are iterated WIDTH cycles, then signs are fixed up in one  |
// | extra cycle before HI/LO are written and done pulses.                 |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module muldiv_seq
   import md_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wr_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH);

   md_state_e          state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] pair_q, pair_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic               res_neg_q, res_neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               accept;
   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [2*WIDTH-1:0] pair_step;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;

   md_iter_step #(
      .WIDTH    (WIDTH)
   ) u_step (
      .is_div   (is_div_q),
      .pair_in  (pair_q),
      .operand  (opnd_q),
      .pair_out (pair_step)
   );

   // Issue decode: operand magnitudes and whether this cycle's request is taken.
   always_comb begin
      accept = (state_q == IDLE) && start && !flush && is_md_op(op);
      a_neg  = is_signed_op(op) && a[WIDTH-1];
      b_neg  = is_signed_op(op) && b[WIDTH-1];
      // Magnitudes are unsigned, so |most-negative| is representable.
      a_mag  = a_neg ? -a : a;
      b_mag  = b_neg ? -b : b;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) state_d = CALC;
         end
         CALC: begin
            if (flush)              state_d = IDLE;
            else if (cnt_q == '0)   state_d = FIX;
         end
         FIX: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath and output next values: operand latch, iteration, sign fix-up, HI/LO writes.
   always_comb begin
      cnt_d     = cnt_q;
      pair_d    = pair_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      res_neg_d = res_neg_q;
      rem_neg_d = rem_neg_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      // Sign-corrected results, only consumed in FIX.
      prod_fix  = res_neg_q ? -pair_q : pair_q;
      quo_fix   = res_neg_q ? -pair_q[WIDTH-1:0] : pair_q[WIDTH-1:0];
      rem_fix   = rem_neg_q ? -pair_q[2*WIDTH-1:WIDTH] : pair_q[2*WIDTH-1:WIDTH];

      // MTHI/MTLO only land while idle; an op issued in the same cycle overwrites later.
      if (!busy_q && wr_hi) hi_d = wr_data;
      if (!busy_q && wr_lo) lo_d = wr_data;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               cnt_d     = CNT_W'(WIDTH - 1);
               is_div_d  = is_div_op(op);
               res_neg_d = a_neg ^ b_neg;
               rem_neg_d = a_neg;
               // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
               if (is_div_op(op)) begin
                  pair_d = {{WIDTH{1'b0}}, a_mag};
                  opnd_d = b_mag;
               end else begin
                  pair_d = {{WIDTH{1'b0}}, b_mag};
                  opnd_d = a_mag;
               end
            end
         end
         CALC: begin
            pair_d = pair_step;
            cnt_d  = cnt_q - CNT_W'(1);
         end
         FIX: begin
            if (!flush) begin
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end
            end
         end
         default: begin
            cnt_d = cnt_q;
         end
      endcase

      busy_d = (state_d != IDLE);
      done_d = (state_q == FIX) && !flush;
   end

   // State register and all datapath flops; rst discards any in-flight op.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pair_q    <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         res_neg_q <= 1'b0;
         rem_neg_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pair_q    <= pair_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         res_neg_q <= res_neg_d;
         rem_neg_q <= rem_neg_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_seq                                                         |
// | Scoreboard bench for muldiv_seq: stimulus pushes expected HI/LO and   |
// | done cycle, an independent monitor pops and compares on each done.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_muldiv_seq;
   import md_pkg::*;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst, start, flush, wr_hi, wr_lo;
   logic [4:0]   op;
   logic [W-1:0] a, b, wr_data;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      int           cyc;
      string        name;
   } exp_t;

   exp_t sb[$];

   muldiv_seq #(.WIDTH(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .flush   (flush),
      .wr_hi   (wr_hi),
      .wr_lo   (wr_lo),
      .wr_data (wr_data),
      .busy    (busy),
      .done    (done),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Reference: returns {HI, LO} from the architectural definition of each op.
   function automatic logic [63:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      logic [63:0] p;
      logic [31:0] xm, ym, qm, rm, q, r;
      p = '0;
      case (o)
         OP_MULTU: p = {32'b0, x} * {32'b0, y};
         OP_MULT:  p = {{32{x[31]}}, x} * {{32{y[31]}}, y};
         OP_DIVU: begin
            if (y == 0) p = {x, 32'hFFFF_FFFF};
            else        p = {x % y, x / y};
         end
         default: begin
            xm = x[31] ? -x : x;
            ym = y[31] ? -y : y;
            if (ym == 0) begin qm = 32'hFFFF_FFFF; rm = xm; end
            else         begin qm = xm / ym;       rm = xm % ym; end
            q = (x[31] ^ y[31]) ? -qm : qm;
            r = x[31] ? -rm : rm;
            p = {r, q};
         end
      endcase
      return p;
   endfunction

   function automatic logic [31:0] pick_val();
      case ($urandom_range(0, 6))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'($urandom_range(0, 20));
         4:       return -32'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL spurious_done: got done=1 at cycle %0d, required no pulse", cyc);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
               chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
               chk({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
               chk({e.name, "_busy_in_done"}, 64'(busy), 64'(0));
            end
         end
      end
   end

   // Call at a negedge with busy low; leaves the bench one negedge later.
   task automatic issue(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                        input string nm, input bit expect_done);
      logic [63:0] r;
      exp_t e;
      r      = model(o, x, y);
      e.hi   = r[63:32];
      e.lo   = r[31:0];
      e.cyc  = cyc + 34;
      e.name = nm;
      if (expect_done) sb.push_back(e);
      op    = o;
      a     = x;
      b     = y;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts busy cycles; returns at the first negedge with busy low (the done cycle).
   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      if (n >= 100) begin
         total++;
         bad++;
         $display("FAIL wait_idle_timeout: busy high for %0d cycles, required <= 33", n);
      end
   endtask

   initial begin
      int n;
      logic [4:0] o;
      rst = 1'b1; start = 1'b0; flush = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
      op = '0; a = '0; b = '0; wr_data = '0;

      repeat (3) @(negedge clk);
      chk("reset_hi",   64'(hi),   64'(0));
      chk("reset_lo",   64'(lo),   64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_done", 64'(done), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Directed ops, each issued in the previous op's done cycle.
      issue(OP_DIVU, 32'd100, 32'd7, "divu_100_7", 1'b1);
      chk("divu_busy_after_start", 64'(busy), 64'(1));
      wait_idle(n);
      chk("divu_busy_cycles", 64'(n), 64'(33));
      chk("divu_100_7_lo_const", 64'(lo), 64'(14));
      chk("divu_100_7_hi_const", 64'(hi), 64'(2));
      issue(OP_DIV,   32'hFFFF_FFF9, 32'd2,         "div_m7_2",     1'b1); wait_idle(n);
      chk("div_m7_2_lo_const", 64'(lo), 64'(32'hFFFF_FFFD));
      chk("div_m7_2_hi_const", 64'(hi), 64'(32'hFFFF_FFFF));
      issue(OP_DIV,   32'd7,         32'hFFFF_FFFE, "div_7_m2",     1'b1); wait_idle(n);
      chk("div_7_m2_lo_const", 64'(lo), 64'(32'hFFFF_FFFD));
      chk("div_7_m2_hi_const", 64'(hi), 64'(1));
      issue(OP_MULT,  32'hFFFF_FFFF, 32'd2,         "mult_m1_2",    1'b1); wait_idle(n);
      chk("mult_m1_2_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
      issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2,         "multu_ff_2",   1'b1); wait_idle(n);
      chk("multu_ff_2_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
      issue(OP_DIVU,  32'd5,         32'd0,         "divu_5_0",     1'b1); wait_idle(n);
      chk("divu_5_0_const", {hi, lo}, 64'h0000_0005_FFFF_FFFF);
      issue(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b1); wait_idle(n);
      chk("div_overflow_const", {hi, lo}, 64'h0000_0000_8000_0000);

      // Illegal op code is ignored; start together with flush is dropped.
      @(negedge clk);
      op = 5'b00001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("illegal_op_busy", 64'(busy), 64'(0));
      op = OP_DIVU; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("start_with_flush_busy", 64'(busy), 64'(0));

      // Preload HI/LO, then flush a MULTU after an ignored in-flight MTHI.
      wr_hi = 1'b1; wr_data = 32'h11;
      @(negedge clk);
      wr_hi = 1'b0; wr_lo = 1'b1; wr_data = 32'h22;
      @(negedge clk);
      wr_lo = 1'b0;
      chk("mt_preload", {hi, lo}, {32'h11, 32'h22});
      issue(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, "multu_flushed", 1'b0);
      repeat (4) @(negedge clk);
      wr_hi = 1'b1; wr_data = 32'hDEAD_BEEF;
      @(negedge clk);
      wr_hi = 1'b0;
      repeat (4) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy_next", 64'(busy), 64'(0));
      repeat (40) @(negedge clk);
      chk("flush_hilo_kept", {hi, lo}, {32'h11, 32'h22});

      // MTLO in the same cycle as start lands at once; result overwrites later.
      wr_lo = 1'b1; wr_data = 32'h55;
      issue(OP_MULT, 32'hFFFF_FFFD, 32'd9, "mult_with_mtlo", 1'b1);
      wr_lo = 1'b0;
      chk("mtlo_with_start", 64'(lo), 64'(32'h55));
      wait_idle(n);

      // Reset in the middle of a DIV.
      @(negedge clk);
      issue(OP_DIV, 32'hFFFF_0000, 32'd3, "div_reset", 1'b0);
      repeat (19) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midop_reset_hilo", {hi, lo}, 64'h0);
      chk("midop_reset_busy", 64'(busy), 64'(0));
      repeat (40) @(negedge clk);
      issue(OP_DIVU, 32'd9, 32'd3, "divu_9_3", 1'b1);
      wait_idle(n);
      chk("divu_9_3_const", {hi, lo}, 64'h0000_0000_0000_0003);

      // Random ops, sometimes back-to-back, sometimes with idle gaps.
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0:       o = OP_DIV;
            1:       o = OP_DIVU;
            2:       o = OP_MULT;
            default: o = OP_MULTU;
         endcase
         if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
         issue(o, pick_val(), pick_val(), $sformatf("rand%0d", i), 1'b1);
         wait_idle(n);
      end

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", 64'(sb.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
